uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
- Synthesizable UART receiver and boot-program loader inside the user project.
- Deserialises 8N1 bytes from the host programmer and assembles them MSB-first into 32-bit instruction words.
- Writes each word into instruction memory at an auto-incrementing word address.
- Stops on the terminator word 0x00000FFF, then hands control to the core.

Parameters:
- CLKS_PER_BIT, 86, clk_i cycles per UART bit (8.6 us bit at a 100 ns clock).
- ADDR_W, 14, word-address width (16384-word instruction memory).
- TERM_WORD, 32'h00000FFF, end-of-program marker; never written to memory.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous active-high reset.
- rx_i  input  1  UART serial input; idle high; asynchronous to clk_i.
- en_i  input  1  loader enable; bytes are accepted only while high.
- ready_o  output  1  loader idle and waiting for program data (drives mprj_ready).
- we_o  output  1  one-cycle instruction-memory write strobe.
- addr_o  output  ADDR_W  word address for we_o.
- wdata_o  output  32  assembled instruction word.
- done_o  output  1  sticky; terminator received or memory full.
- frame_err_o  output  1  sticky; a stop bit was sampled low.
- ovf_o  output  1  sticky; DEPTH words written before the terminator arrived.

Behaviour:
- Reset (rst_i sampled high at a clk_i edge) forces:
  - all outputs to 0;
  - rx synchroniser flops to 1;
  - FSM to IDLE;
  - byte index, address and bit counters to 0.
- Reset mid-byte or mid-word discards partial data. There is no memory write during or after reset.
- rx_i passes through a 2-flop synchroniser; only rx_s is used. Input-to-detect latency is 2 cycles.
- ready_o = en_i & (state==IDLE) & ~done_o.
- Receive FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on rx_s==0 with en_i & ~done_o, clear clk_cnt and go to START.
  - START: at clk_cnt==CLKS_PER_BIT/2-1 (mid start bit):
    - rx_s==0: clear clk_cnt, bit_idx=0, go to DATA;
    - rx_s==1: glitch, return to IDLE.
  - DATA: sample rx_s every CLKS_PER_BIT cycles into shift[bit_idx], LSB first. After bit 7 go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s:
    - 1: byte valid, go to IDLE;
    - 0: set frame_err_o, discard the byte (byte index unchanged), go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE.
- Start bits stretched by up to CLKS_PER_BIT/2-1 cycles must still decode correctly. The sender inserts a 10-cycle stretch.
- Word assembly:
  - Byte 0 goes to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
  - byte_idx wraps 3 to 0.
- On the valid 4th byte (the cycle after the STOP sample), compare the word against TERM_WORD:
  - Equal: set done_o; no write.
  - Not equal: pulse we_o for exactly 1 cycle with wdata_o = word and addr_o = current address. Address increments after the write.
- addr_o and wdata_o hold their values between writes.
- If the address wraps from 2^ADDR_W-1 after a write: set ovf_o and done_o; no further writes.
- Once done_o is set, rx_s activity is ignored until reset.
- en_i deasserted mid-byte: the current byte completes. New start bits are not accepted while en_i==0.
- frame_err_o does not block further reception.

Test Plan:
- Reset, rx_i=1, en_i=1 -> ready_o=1 within 3 cycles; we_o=0, done_o=0, addr_o=0.
- Send bytes 0x12,0x34,0x56,0x78 at 86 clks/bit, start bit stretched by 10 clks -> one we_o pulse, wdata_o=0x12345678, addr_o=0. Next word lands at addr 1.
- Send 3 words, then 00,00,0F,FF -> exactly 3 writes (addr 0..2), then done_o=1 and ready_o=0. Further bytes cause no writes.
- 20-cycle low glitch on idle rx_i -> START rejects it; no byte assembled; ready_o returns to 1.
- Byte 0xAA sent with its stop bit held low, then line released -> frame_err_o=1. Next four good bytes 0xDEADBEEF are written at addr 0.
- ADDR_W=2, send 4 non-terminator words -> writes at addr 0..3, then ovf_o=1 and done_o=1. A 5th word is not written.
- rst_i pulsed after 2 bytes of a word -> no write. A following 4-byte word is written to addr 0 with the correct value.

Source files
------------

// File: rtl/uart_prog_loader.sv
`timescale 1ns/1ps
// UART 8N1 receiver that assembles MSB-first 32-bit words and streams
// them into instruction memory until the terminator word arrives.
module uart_prog_loader #(
    parameter int          CLKS_PER_BIT = 86,
    parameter int          ADDR_W       = 14,
    parameter logic [31:0] TERM_WORD    = 32'h00000FFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    input  logic              en_i,
    output logic              ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic              done_o,
    output logic              frame_err_o,
    output logic              ovf_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, WAIT_HIGH
    } state_t;

    state_t            state, state_nxt;
    logic              rx_m, rx_s;
    logic [CW-1:0]     clk_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic [1:0]        byte_idx;
    logic [23:0]       word;
    logic [ADDR_W-1:0] addr;
    logic              cnt_clr, bit_take, byte_ok, byte_bad;
    logic [31:0]       full_word;

    // the three earlier bytes sit in word; the fourth is still in shift
    assign full_word = {word, shift};
    assign ready_o   = en_i & (state == IDLE) & ~done_o;

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        bit_take  = 1'b0;
        byte_ok   = 1'b0;
        byte_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s && en_i && !done_o) begin
                    cnt_clr   = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (clk_cnt == HALF) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == FULL) begin
                    cnt_clr  = 1'b1;
                    bit_take = 1'b1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (clk_cnt == FULL) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        byte_ok   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        byte_bad  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            byte_idx    <= '0;
            word        <= '0;
            addr        <= '0;
            we_o        <= 1'b0;
            addr_o      <= '0;
            wdata_o     <= '0;
            done_o      <= 1'b0;
            frame_err_o <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            rx_m    <= rx_i;
            rx_s    <= rx_m;
            state   <= state_nxt;
            clk_cnt <= cnt_clr ? '0 : clk_cnt + 1'b1;
            we_o    <= 1'b0;
            if (state == START) bit_idx <= '0;
            if (bit_take) begin
                shift[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + 3'd1;
            end
            if (byte_bad) frame_err_o <= 1'b1;
            if (byte_ok && !done_o) begin
                byte_idx <= byte_idx + 2'd1;
                word     <= {word[15:0], shift};
                if (byte_idx == 2'd3) begin
                    if (full_word == TERM_WORD) begin
                        done_o <= 1'b1;
                    end else begin
                        we_o    <= 1'b1;
                        wdata_o <= full_word;
                        addr_o  <= addr;
                        addr    <= addr + 1'b1;
                        // last slot filled: memory full
                        if (addr == '1) begin
                            ovf_o  <= 1'b1;
                            done_o <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
`timescale 1ns/1ps
// Randomised bench for uart_prog_loader: a UART sender drives two DUTs
// (full-size and a 4-word memory) and writes are checked against a model.
module tb_uart_prog_loader;

    localparam logic [31:0] TERM = 32'h00000FFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rx, en;
    logic        ready, we, done, ferr, ovf;
    logic [13:0] addr;
    logic [31:0] wdata;

    logic        rst2, rx2, en2;
    logic        ready2, we2, done2, ferr2, ovf2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;

    uart_prog_loader dut (
        .clk_i(clk), .rst_i(rst), .rx_i(rx), .en_i(en),
        .ready_o(ready), .we_o(we), .addr_o(addr),
        .wdata_o(wdata), .done_o(done),
        .frame_err_o(ferr), .ovf_o(ovf)
    );

    uart_prog_loader #(.CLKS_PER_BIT(16), .ADDR_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst2), .rx_i(rx2), .en_i(en2),
        .ready_o(ready2), .we_o(we2), .addr_o(addr2),
        .wdata_o(wdata2), .done_o(done2),
        .frame_err_o(ferr2), .ovf_o(ovf2)
    );

    int checks = 0;
    int passed = 0;
    int we_long = 0;
    logic we_prev = 1'b0;
    logic we2_prev = 1'b0;

    logic [45:0] got0[$];
    logic [45:0] got1[$];
    logic [45:0] exp0[$];
    logic [45:0] exp1[$];
    int exp_addr[2];
    bit exp_done[2];
    bit exp_ovf[2];

    // capture every write strobe; a strobe seen on two cycles is an error
    always @(negedge clk) begin
        if (we) got0.push_back({addr, wdata});
        if (we2) got1.push_back({12'd0, addr2, wdata2});
        if ((we && we_prev) || (we2 && we2_prev))
            we_long <= we_long + 1;
        we_prev  <= we;
        we2_prev <= we2;
    end

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == TERM) w = w ^ 32'h1;
        return w;
    endfunction

    // memory image model: each word either ends loading or takes next slot
    function automatic void model_word(int which, logic [31:0] w);
        int depth;
        depth = (which == 0) ? 16384 : 4;
        if (exp_done[which]) return;
        if (w == TERM) begin
            exp_done[which] = 1'b1;
            return;
        end
        if (which == 0) exp0.push_back({14'(exp_addr[0]), w});
        else exp1.push_back({14'(exp_addr[1]), w});
        exp_addr[which] = (exp_addr[which] + 1) % depth;
        if (exp_addr[which] == 0) begin
            exp_ovf[which]  = 1'b1;
            exp_done[which] = 1'b1;
        end
    endfunction

    task automatic drive(int which, logic v);
        if (which == 0) rx = v;
        else rx2 = v;
    endtask

    task automatic do_reset(int which);
        @(negedge clk);
        if (which == 0) rst = 1'b1;
        else rst2 = 1'b1;
        repeat (3) @(negedge clk);
        if (which == 0) begin
            rst = 1'b0;
            got0.delete();
            exp0.delete();
        end else begin
            rst2 = 1'b0;
            got1.delete();
            exp1.delete();
        end
        exp_addr[which] = 0;
        exp_done[which] = 1'b0;
        exp_ovf[which]  = 1'b0;
    endtask

    task automatic send_byte(int which, logic [7:0] b,
                             bit stop_ok, int stretch);
        int cpb;
        cpb = (which == 0) ? 86 : 16;
        @(negedge clk);
        drive(which, 1'b0);
        repeat (cpb + stretch) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(which, b[i]);
            repeat (cpb) @(negedge clk);
        end
        drive(which, stop_ok);
        repeat (cpb) @(negedge clk);
        drive(which, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_word(int which, logic [31:0] w);
        int st;
        st = (which == 0) ? 10 : 3;
        send_byte(which, w[31:24], 1'b1, st);
        send_byte(which, w[23:16], 1'b1, st);
        send_byte(which, w[15:8], 1'b1, st);
        send_byte(which, w[7:0], 1'b1, st);
        model_word(which, w);
    endtask

    task automatic test_reset();
        int k;
        do_reset(0);
        k = 0;
        while (!ready && k < 3) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", ready);
        else passed++;
        checks++;
        if ({we, done, ferr, ovf} !== 4'b0)
            $display("FAIL reset_flags got=%b want=0000",
                     {we, done, ferr, ovf});
        else passed++;
        checks++;
        if (addr !== 14'd0 || wdata !== 32'd0)
            $display("FAIL reset_addr got=%h/%h want=0/0", addr, wdata);
        else passed++;
    endtask

    task automatic test_basic();
        do_reset(0);
        send_word(0, 32'h12345678);
        send_word(0, rand_word());
        checks++;
        if (got0.size() !== 2)
            $display("FAIL basic_count got=%0d want=2", got0.size());
        else passed++;
        for (int i = 0; i < 2 && i < got0.size(); i++) begin
            checks++;
            if (got0[i] !== exp0[i])
                $display("FAIL basic_wr%0d got=%h want=%h",
                         i, got0[i], exp0[i]);
            else passed++;
        end
    endtask

    task automatic test_glitch();
        do_reset(0);
        @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || got0.size() !== 0)
            $display("FAIL glitch_idle got=%b/%0d want=1/0",
                     ready, got0.size());
        else passed++;
        send_word(0, rand_word());
        checks++;
        if (got0.size() !== 1 || got0[0] !== exp0[0])
            $display("FAIL glitch_word got=%0d want=%h writes",
                     got0.size(), exp0[0]);
        else passed++;
    endtask

    task automatic test_frame();
        do_reset(0);
        send_byte(0, 8'hAA, 1'b0, 10);
        checks++;
        if (ferr !== 1'b1) $display("FAIL frame_flag got=%b want=1", ferr);
        else passed++;
        send_word(0, 32'hDEADBEEF);
        checks++;
        if (got0.size() !== 1 || got0[0] !== {14'd0, 32'hDEADBEEF})
            $display("FAIL frame_word got=%0d writes want=1 at 0",
                     got0.size());
        else passed++;
        checks++;
        if (ferr !== 1'b1) $display("FAIL frame_sticky got=%b want=1", ferr);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        do_reset(0);
        send_byte(0, 8'($urandom), 1'b1, 10);
        send_byte(0, 8'($urandom), 1'b1, 10);
        do_reset(0);
        w = rand_word();
        send_word(0, w);
        checks++;
        if (got0.size() !== 1 || got0[0] !== {14'd0, w})
            $display("FAIL rstmid_word got=%0d writes want=1 of %h",
                     got0.size(), w);
        else passed++;
    endtask

    task automatic test_enable();
        do_reset(0);
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) $display("FAIL en_ready got=%b want=0", ready);
        else passed++;
        send_word(0, rand_word());
        exp0.delete();
        exp_addr[0] = 0;
        checks++;
        if (got0.size() !== 0)
            $display("FAIL en_nowrite got=%0d want=0", got0.size());
        else passed++;
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) $display("FAIL en_ready2 got=%b want=1", ready);
        else passed++;
    endtask

    task automatic test_term();
        do_reset(0);
        for (int i = 0; i < 3; i++) send_word(0, rand_word());
        send_word(0, TERM);
        checks++;
        if (got0.size() !== exp0.size())
            $display("FAIL term_count got=%0d want=%0d",
                     got0.size(), exp0.size());
        else passed++;
        for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
            checks++;
            if (got0[i] !== exp0[i])
                $display("FAIL term_wr%0d got=%h want=%h",
                         i, got0[i], exp0[i]);
            else passed++;
        end
        checks++;
        if (done !== exp_done[0] || ready !== 1'b0 || ovf !== 1'b0)
            $display("FAIL term_done got=%b%b%b want=%b00",
                     done, ready, ovf, exp_done[0]);
        else passed++;
        send_word(0, rand_word());
        checks++;
        if (got0.size() !== 3 || done !== 1'b1)
            $display("FAIL term_after got=%0d/%b want=3/1",
                     got0.size(), done);
        else passed++;
    endtask

    task automatic test_ovf();
        do_reset(1);
        for (int i = 0; i < 5; i++) send_word(1, rand_word());
        checks++;
        if (got1.size() !== exp1.size())
            $display("FAIL ovf_count got=%0d want=%0d",
                     got1.size(), exp1.size());
        else passed++;
        for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
            checks++;
            if (got1[i] !== exp1[i])
                $display("FAIL ovf_wr%0d got=%h want=%h",
                         i, got1[i], exp1[i]);
            else passed++;
        end
        checks++;
        if (ovf2 !== exp_ovf[1] || done2 !== exp_done[1])
            $display("FAIL ovf_flags got=%b%b want=%b%b",
                     ovf2, done2, exp_ovf[1], exp_done[1]);
        else passed++;
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; en = 1'b1;
        rst2 = 1'b1; rx2 = 1'b1; en2 = 1'b1;
        do_reset(1);
        test_reset();
        test_basic();
        test_glitch();
        test_frame();
        test_reset_mid();
        test_enable();
        test_term();
        test_ovf();
        checks++;
        if (we_long !== 0)
            $display("FAIL we_width got=%0d long pulses want=0", we_long);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
